// File: rtl/table_stepper.sv
// Table stepper: walks the table lines on TTL/software triggers and hands each line to the DDS writer.
// Optional extTrig glitch filter enabled by defining TRIG_GLITCH_FILTER_EN.
module table_stepper #(
  parameter int LINES_W     = 10,
  parameter int FILT_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arm,
  input  logic [1:0]         rcontrol,
  input  logic [LINES_W-1:0] rlines,
  input  logic               extTrig,
  input  logic               softTrig,
  input  logic [6:0]         fifo_empty,
  input  logic [31:0]        fifo_time,
  input  logic               load_ack,
  output logic               load_req,
  output logic               rdreq,
  output logic [LINES_W-1:0] line_idx,
  output logic               busy,
  output logic               done,
  output logic               underrun,
  output logic               trig_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_LOAD, S_POP, S_DWELL, S_ARM_AUTO, S_DONE
  } state_t;

  if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : gBadFilt
    $error("table_stepper: FILT_CYCLES must be in 1..255");
  end

  logic syncA_q, syncB_q, levelPrev_q, extEdge_q;
  logic extLevel;
  logic trig;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      syncA_q     <= 1'b0;
      syncB_q     <= 1'b0;
      levelPrev_q <= 1'b0;
      extEdge_q   <= 1'b0;
    end else begin
      syncA_q     <= extTrig;
      syncB_q     <= syncA_q;
      levelPrev_q <= extLevel;
      extEdge_q   <= extLevel & ~levelPrev_q;
    end
  end

`ifdef TRIG_GLITCH_FILTER_EN
  localparam logic [7:0] FILT_N = 8'(FILT_CYCLES);
  logic [7:0] filtCnt_q;
  logic       filt_q;

  // Any low sample restarts the run of consecutive highs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filtCnt_q <= 8'd0;
      filt_q    <= 1'b0;
    end else if (!syncB_q) begin
      filtCnt_q <= 8'd0;
      filt_q    <= 1'b0;
    end else begin
      if (filtCnt_q != FILT_N) filtCnt_q <= filtCnt_q + 8'd1;
      filt_q <= (filtCnt_q >= FILT_N - 8'd1);
    end
  end

  assign extLevel = filt_q;
`else
  assign extLevel = syncB_q;
`endif

  assign trig = extEdge_q | softTrig;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic [LINES_W-1:0] idx_q, idx_d;
  logic [31:0]        dwell_q, dwell_d;
  logic               pend_q, pend_d;
  logic               underrun_q, underrun_d;
  logic               overrun_q, overrun_d;
  logic [LINES_W-1:0] idxNext;
  logic               stepMode;

  assign idxNext  = idx_q + LINES_W'(1);
  assign stepMode = (mode_q != 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'd0;
      lines_q    <= '0;
      idx_q      <= '0;
      dwell_q    <= 32'd0;
      pend_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lines_q    <= lines_d;
      idx_q      <= idx_d;
      dwell_q    <= dwell_d;
      pend_q     <= pend_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lines_d    = lines_q;
    idx_d      = idx_q;
    dwell_d    = dwell_q;
    pend_d     = pend_q;
    underrun_d = underrun_q;
    overrun_d  = overrun_q;
    load_req   = 1'b0;
    rdreq      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // The decision uses the values being latched this cycle.
        if (arm) begin
          mode_d     = rcontrol;
          lines_d    = rlines;
          idx_d      = '0;
          underrun_d = 1'b0;
          overrun_d  = 1'b0;
          pend_d     = 1'b0;
          state_d    = (rcontrol == 2'd0 || rlines == '0) ? S_DONE : S_ARM;
        end
      end
      S_ARM: begin
        if (trig || pend_q) begin
          pend_d = 1'b0;
          if (|fifo_empty) begin
            underrun_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_ARM_AUTO: begin
        if (|fifo_empty) begin
          underrun_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_req = 1'b1;
        if (load_ack) begin
          dwell_d = (fifo_time == 32'd0) ? 32'd1 : fifo_time;
          state_d = S_POP;
        end
      end
      S_POP: begin
        rdreq = 1'b1;
        idx_d = idxNext;
        if (idxNext == lines_q)    state_d = S_DONE;
        else if (mode_q == 2'd2)   state_d = S_DWELL;
        else                       state_d = S_ARM;
      end
      S_DWELL: begin
        if (dwell_q <= 32'd1) state_d = S_ARM_AUTO;
        else                  dwell_d = dwell_q - 32'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Step mode keeps one trigger in reserve while a line is in flight.
    if (stepMode && trig &&
        (state_q == S_LOAD || state_q == S_POP || state_q == S_DWELL)) begin
      if (pend_q) overrun_d = 1'b1;
      else        pend_d    = 1'b1;
    end
  end

  assign line_idx     = (lines_q != '0 && idx_q >= lines_q) ? (lines_q - LINES_W'(1)) : idx_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign underrun     = underrun_q;
  assign trig_overrun = overrun_q;

endmodule

// File: tb/tb_table_stepper.sv
// Scoreboard bench for table_stepper: expected loads are queued by the stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_table_stepper;
  localparam int LINES_W     = 10;
  localparam int FILT_CYCLES = 8;
`ifdef TRIG_GLITCH_FILTER_EN
  localparam int EXT_LAT   = 2 + FILT_CYCLES + 1 + 1;
  localparam int EXT_PULSE = 12;
`else
  localparam int EXT_LAT   = 4;
  localparam int EXT_PULSE = 3;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               arm = 1'b0;
  logic [1:0]         rcontrol = 2'd0;
  logic [LINES_W-1:0] rlines = '0;
  logic               extTrig = 1'b0;
  logic               softTrig = 1'b0;
  logic [6:0]         fifoEmpty;
  logic [31:0]        fifoTime;
  logic               loadAck = 1'b0;
  logic               loadReq, rdreq, busy, done, underrun, trigOverrun;
  logic [LINES_W-1:0] lineIdx;

  table_stepper #(.LINES_W(LINES_W), .FILT_CYCLES(FILT_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .rcontrol(rcontrol), .rlines(rlines),
    .extTrig(extTrig), .softTrig(softTrig), .fifo_empty(fifoEmpty), .fifo_time(fifoTime),
    .load_ack(loadAck), .load_req(loadReq), .rdreq(rdreq), .line_idx(lineIdx),
    .busy(busy), .done(done), .underrun(underrun), .trig_overrun(trigOverrun)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int gap; } exp_t;
  exp_t expQ[$];
  int checkCount = 0;
  int passCount  = 0;
  int rdCount    = 0;
  int cyc        = 0;
  int refCyc     = 0;
  logic ackEn    = 1'b1;

  // Shared model of the seven FIFOs: only the TIME head matters here.
  logic [31:0] memT [16];
  logic [4:0]  wrPtr = '0;
  logic [4:0]  rdPtr = '0;
  logic        flushReq = 1'b0;

  assign fifoEmpty = (wrPtr == rdPtr) ? 7'h7F : 7'h00;
  assign fifoTime  = memT[rdPtr[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flushReq) rdPtr <= wrPtr;
    else if (rdreq && wrPtr != rdPtr) rdPtr <= rdPtr + 5'd1;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic pushLine(input int t);
    memT[wrPtr[3:0]] = t;
    wrPtr = wrPtr + 5'd1;
  endtask

  task automatic expectLoad(input int idx, input int gap);
    exp_t e;
    e.idx = idx;
    e.gap = gap;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [1:0] rc, input int rl);
    @(negedge clk);
    rcontrol = rc;
    rlines   = LINES_W'(rl);
    arm      = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulseSoft();
    @(negedge clk);
    softTrig = 1'b1;
    @(negedge clk);
    softTrig = 1'b0;
  endtask

  task automatic pulseExt(input int len);
    @(negedge clk);
    extTrig = 1'b1;
    repeat (len) @(negedge clk);
    extTrig = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_done", done, 1);
  endtask

  task automatic waitReq(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!loadReq && n < budget);
    checkOutput("wait_load_req", loadReq, 1);
  endtask

  // DDS writer model: acknowledges each request two cycles after it appears.
  initial begin
    forever begin
      @(negedge clk);
      if (ackEn && loadReq && !loadAck) begin
        repeat (2) @(negedge clk);
        if (ackEn && loadReq) begin
          refCyc  = cyc + 1;
          loadAck = 1'b1;
          @(negedge clk);
          loadAck = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    logic prevReq;
    prevReq = 1'b0;
    forever begin
      @(negedge clk);
      if (rdreq) rdCount++;
      if (loadReq && !prevReq) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_load: got load of line %0d, expected none", lineIdx);
        end else begin
          e = expQ.pop_front();
          checkOutput("load_idx", lineIdx, e.idx);
          if (e.gap >= 0) checkOutput("load_gap", cyc - refCyc, e.gap);
        end
      end
      prevReq = loadReq;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    waitCycles(3);
    checkOutput("reset_load_req", loadReq, 0);
    checkOutput("reset_rdreq", rdreq, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_underrun", underrun, 0);
    checkOutput("reset_overrun", trigOverrun, 0);
    checkOutput("reset_line_idx", lineIdx, 0);
    @(negedge clk);
    reset_n = 1'b1;
    waitCycles(2);

    $display("[TB] step mode");
    base = rdCount;
    pushLine(10); pushLine(20); pushLine(30);
    applyStimulus(2'd1, 3);
    checkOutput("step_busy", busy, 1);
    for (int i = 0; i < 3; i++) expectLoad(i, -1);
    for (int i = 0; i < 3; i++) begin
      pulseExt(3);
      waitCycles(14);
    end
    waitDone(20);
    checkOutput("step_rd_count", rdCount - base, 3);
    checkOutput("step_underrun", underrun, 0);
    checkOutput("step_line_idx", lineIdx, 2);
    checkOutput("step_queue_left", expQ.size(), 0);

    $display("[TB] run mode");
    base = rdCount;
    pushLine(100); pushLine(0); pushLine(5); pushLine(7);
    applyStimulus(2'd2, 4);
    expectLoad(0, -1);
    expectLoad(1, 102);
    expectLoad(2, 3);
    expectLoad(3, 7);
    pulseSoft();
    waitDone(400);
    checkOutput("run_rd_count", rdCount - base, 4);
    checkOutput("run_queue_left", expQ.size(), 0);
    pulseSoft();
    pulseExt(3);
    waitCycles(20);
    checkOutput("run_extra_rd_count", rdCount - base, 4);
    checkOutput("run_done_held", done, 1);

    $display("[TB] underrun");
    base = rdCount;
    pushLine(1); pushLine(1);
    applyStimulus(2'd1, 5);
    expectLoad(0, -1);
    expectLoad(1, -1);
    for (int i = 0; i < 3; i++) begin
      pulseSoft();
      waitCycles(12);
    end
    checkOutput("under_flag", underrun, 1);
    checkOutput("under_done", done, 1);
    checkOutput("under_rd_count", rdCount - base, 2);
    checkOutput("under_line_idx", lineIdx, 2);
    checkOutput("under_queue_left", expQ.size(), 0);

    $display("[TB] pending and overrun");
    base = rdCount;
    pushLine(1); pushLine(1); pushLine(1);
    applyStimulus(2'd1, 3);
    checkOutput("pend_underrun_cleared", underrun, 0);
    checkOutput("pend_overrun_clear", trigOverrun, 0);
    expectLoad(0, -1);
    expectLoad(1, -1);
    pulseSoft();
    waitReq(20);
    softTrig = 1'b1;
    @(negedge clk);
    softTrig = 1'b0;
    @(negedge clk);
    softTrig = 1'b1;
    @(negedge clk);
    softTrig = 1'b0;
    waitCycles(15);
    checkOutput("pend_overrun", trigOverrun, 1);
    checkOutput("pend_rd_count", rdCount - base, 2);
    checkOutput("pend_not_done", done, 0);
    checkOutput("pend_line_idx", lineIdx, 2);
    checkOutput("pend_queue_left", expQ.size(), 0);
    expectLoad(2, -1);
    pulseSoft();
    waitDone(30);
    checkOutput("pend_final_rd_count", rdCount - base, 3);
    checkOutput("pend_overrun_sticky", trigOverrun, 1);

    $display("[TB] reset mid-load");
    base = rdCount;
    pushLine(9);
    ackEn = 1'b0;
    applyStimulus(2'd1, 1);
    expectLoad(0, -1);
    pulseSoft();
    waitReq(20);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_load_req", loadReq, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rdreq", rdreq, 0);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("rst_fifo_untouched", int'(wrPtr - rdPtr), 1);
    ackEn = 1'b1;
    applyStimulus(2'd0, 3);
    checkOutput("static_done", done, 1);
    checkOutput("static_busy", busy, 0);
    waitCycles(10);
    checkOutput("static_rd_count", rdCount - base, 0);
    flushReq = 1'b1;
    @(negedge clk);
    flushReq = 1'b0;

    $display("[TB] external trigger latency");
    base = rdCount;
    pushLine(4);
    applyStimulus(2'd1, 1);
`ifdef TRIG_GLITCH_FILTER_EN
    pulseExt(5);
    waitCycles(20);
    checkOutput("glitch_rd_count", rdCount - base, 0);
    checkOutput("glitch_busy", busy, 1);
`endif
    expectLoad(0, EXT_LAT);
    @(negedge clk);
    extTrig = 1'b1;
    refCyc  = cyc;
    repeat (EXT_PULSE) @(negedge clk);
    extTrig = 1'b0;
    waitDone(60);
    checkOutput("lat_rd_count", rdCount - base, 1);
    checkOutput("lat_queue_left", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
